opnd_fetch_seq: RTL

//  Sequences operand fetch for one decoded instruction at a time, downstream of decode_opnds.

---
 rtl/opnd_fetch_seq_pkg.sv | 36 +++
 rtl/opnd_fetch_seq_mask.sv | 10 +
 rtl/opnd_fetch_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/opnd_fetch_seq_pkg.sv
// opnd_fetch_seq_pkg: operand-form encodings, sequencer states and fault codes
// shared by the operand fetch sequencer and its bench.
package opnd_fetch_seq_pkg;

    localparam logic [3:0] OPND_ENC_NONE                = 4'd0;
    localparam logic [3:0] OPND_ENC_IMM                 = 4'd1;
    localparam logic [3:0] OPND_ENC_REG                 = 4'd2;
    localparam logic [3:0] OPND_ENC_REG_IMM             = 4'd3;
    localparam logic [3:0] OPND_ENC_MODREGRM_RM_REG     = 4'd4;
    localparam logic [3:0] OPND_ENC_MODREGRM_RM_IMM     = 4'd5;
    localparam logic [3:0] OPND_ENC_MODREGRM_REG_RM     = 4'd6;
    localparam logic [3:0] OPND_ENC_MODREGRM_REG_RM_IMM = 4'd7;

    localparam logic [1:0] OPND_FAULT_NONE    = 2'd0;
    localparam logic [1:0] OPND_FAULT_MEM_ERR = 2'd1;
    localparam logic [1:0] OPND_FAULT_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        SEQ_IDLE     = 3'd0,
        SEQ_MEM_REQ  = 3'd1,
        SEQ_MEM_WAIT = 3'd2,
        SEQ_DRAIN    = 3'd3,
        SEQ_OUT      = 3'd4
    } seq_e;

    function automatic logic is_rm_form(input logic [3:0] form);
        return form inside {OPND_ENC_MODREGRM_RM_REG, OPND_ENC_MODREGRM_RM_IMM,
                            OPND_ENC_MODREGRM_REG_RM, OPND_ENC_MODREGRM_REG_RM_IMM};
    endfunction

    // r/m operand lives in slot 1 for the reg,r/m forms, slot 0 otherwise
    function automatic logic rm_slot_of(input logic [3:0] form);
        return form == OPND_ENC_MODREGRM_REG_RM || form == OPND_ENC_MODREGRM_REG_RM_IMM;
    endfunction

endpackage

// File: rtl/opnd_fetch_seq_mask.sv
// opnd_width_mask: zero-extends load data to the operand width; 8-bit beats 16-bit.
module opnd_width_mask (
    input  logic [31:0] data,
    input  logic        reg_1byte,
    input  logic        prefix_operand_16bit,
    output logic [31:0] masked
);
    assign masked = reg_1byte ? {24'd0, data[7:0]} :
                    prefix_operand_16bit ? {16'd0, data[15:0]} : data;
endmodule

// File: rtl/opnd_fetch_seq.sv
// opnd_fetch_seq: sequences operand fetch for one decoded instruction, issuing a single
// load for memory r/m operands and handing the final operand bundle to execute.
module opnd_fetch_seq
    import opnd_fetch_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  opnd_form,
    input  logic [7:0]  modrm,
    input  logic [31:0] mem_addr,
    input  logic [31:0] opnd0_in,
    input  logic [31:0] opnd1_in,
    input  logic [31:0] opnd2_in,
    input  logic        reg_1byte,
    input  logic        prefix_operand_16bit,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] opnd0_out,
    output logic [31:0] opnd1_out,
    output logic [31:0] opnd2_out,
    output logic        fault,
    output logic [1:0]  fault_code
);
    seq_e             state;
    logic             rm_slot;
    logic             byte_w;
    logic             half_w;
    logic             drain_flush;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rsp_masked;
    logic             is_mem;

    assign is_mem        = is_rm_form(opnd_form) && modrm[7:6] != 2'b11;
    assign in_ready      = state == SEQ_IDLE;
    assign mem_req_valid = state == SEQ_MEM_REQ;
    assign out_valid     = state == SEQ_OUT;
    assign fault         = fault_code != OPND_FAULT_NONE;

    opnd_width_mask u_mask (
        .data                 (mem_rsp_data),
        .reg_1byte            (byte_w),
        .prefix_operand_16bit (half_w),
        .masked               (rsp_masked)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SEQ_IDLE;
            opnd0_out    <= '0;
            opnd1_out    <= '0;
            opnd2_out    <= '0;
            mem_req_addr <= '0;
            cnt          <= '0;
            rm_slot      <= 1'b0;
            byte_w       <= 1'b0;
            half_w       <= 1'b0;
            drain_flush  <= 1'b0;
            fault_code   <= OPND_FAULT_NONE;
        end else begin
            case (state)
                SEQ_IDLE: if (in_valid) begin
                    opnd0_out    <= opnd0_in;
                    opnd1_out    <= opnd1_in;
                    opnd2_out    <= opnd2_in;
                    mem_req_addr <= mem_addr;
                    rm_slot      <= rm_slot_of(opnd_form);
                    byte_w       <= reg_1byte;
                    half_w       <= prefix_operand_16bit;
                    state        <= is_mem ? SEQ_MEM_REQ : SEQ_OUT;
                end
                SEQ_MEM_REQ: if (flush) begin
                    // an accepted request still owes a response, so it must be drained
                    state       <= mem_req_ready ? SEQ_DRAIN : SEQ_IDLE;
                    drain_flush <= 1'b1;
                end else if (mem_req_ready) begin
                    state <= SEQ_MEM_WAIT;
                    cnt   <= '0;
                end
                SEQ_MEM_WAIT: if (flush) begin
                    state       <= mem_rsp_valid ? SEQ_IDLE : SEQ_DRAIN;
                    drain_flush <= 1'b1;
                end else if (mem_rsp_valid) begin
                    state <= SEQ_OUT;
                    if (mem_rsp_err) fault_code <= OPND_FAULT_MEM_ERR;
                    else if (rm_slot) opnd1_out <= rsp_masked;
                    else opnd0_out <= rsp_masked;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                    state       <= SEQ_DRAIN;
                    drain_flush <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                SEQ_DRAIN: if (drain_flush) begin
                    if (mem_rsp_valid) state <= SEQ_IDLE;
                end else if (flush) begin
                    state <= SEQ_IDLE;
                end else begin
                    state      <= SEQ_OUT;
                    fault_code <= OPND_FAULT_TIMEOUT;
                end
                SEQ_OUT: if (flush || out_ready) begin
                    state      <= SEQ_IDLE;
                    fault_code <= OPND_FAULT_NONE;
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

endmodule
